// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg
//   Shared defaults for the sliding-window generator and the multiply-adder
//   that consumes its output. WINDOW_WIDTH is the multiply-adder input
//   vector width for the default kernel configuration.
package conv_window_gen_pkg;

  localparam int DEF_PIXEL_WIDTH  = 8;
  localparam int DEF_KERNEL_SIZE  = 3;
  localparam int DEF_IMAGE_WIDTH  = 32;
  localparam int DEF_IMAGE_HEIGHT = 32;

  localparam int WINDOW_WIDTH = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE * DEF_PIXEL_WIDTH;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer
//   One image row of delay: a circular buffer of DEPTH pixels addressed by
//   the shared column counter. The read is combinational, so on an accepted
//   pixel dout_o returns the pixel written at this column one row earlier,
//   and the same edge overwrites it with din_i (read-before-write).
//   Storage is intentionally not reset; consumers gate on counter state.
// Ports
//   clock    rising-edge clock
//   wr_en_i  accepted pixel this cycle
//   addr_i   column of the accepted pixel
//   din_i    pixel entering the row delay
//   dout_o   pixel leaving the row delay (same column, previous row)
module conv_line_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int DEPTH       = 32,
  parameter int AW          = 5
) (
  input  logic                   clock,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [PIXEL_WIDTH-1:0] din_i,
  output logic [PIXEL_WIDTH-1:0] dout_o
);

  logic [PIXEL_WIDTH-1:0] mem_q [DEPTH];

  assign dout_o = mem_q[addr_i];

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[addr_i] <= din_i;
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Sliding-window generator feeding the convolution multiply-adder. Takes a
//   raster-order pixel stream (one pixel/cycle, gaps allowed), keeps the last
//   KERNEL_SIZE-1 rows in chained line buffers and emits every fully valid
//   KxK window (no padding), flattened with element r*K+c at
//   out_window[PW*(i+1)-1 : PW*i], r=0 top row, c=0 leftmost column.
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-low
//   in_valid        in_pixel valid this cycle
//   in_sof          start of frame, forces the pixel to position (0,0)
//   in_pixel        raster-order pixel
//   out_valid       one-cycle strobe, out_window holds a complete window
//   out_window      flattened KxK window
//   out_frame_done  pulse with the last window of a frame
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       in_valid,
  input  logic                                       in_sof,
  input  logic [PIXEL_WIDTH-1:0]                     in_pixel,
  output logic                                       out_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] out_window,
  output logic                                       out_frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int PW = PIXEL_WIDTH;
  localparam int CW = ctr_width(IMAGE_WIDTH);
  localparam int RW = ctr_width(IMAGE_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  // ---------------------------------------------------------------------
  // Position counters. in_sof overrides the stored position so a stream
  // can be resynchronised at any pixel; *_cur is the position of the pixel
  // being presented this cycle.
  // ---------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic          win_done, frame_end;

  always_comb begin
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  // Validity depends only on position, so stale line-buffer data from an
  // earlier frame (or from before reset) is never presented as a window.
  assign win_done  = in_valid && (row_cur >= ROW_MIN) && (col_cur >= COL_MIN);
  assign frame_end = win_done && (row_cur == ROW_LAST) && (col_cur == COL_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------------------------------------------------------------
  // Line-buffer chain: lb[0] delays the input by one row, lb[g] delays
  // lb[g-1] by another row. All share the column address.
  // ---------------------------------------------------------------------
  logic [K-2:0][PW-1:0] lb_in, lb_out;

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    if (g == 0) begin : g_head
      assign lb_in[g] = in_pixel;
    end else begin : g_chain
      assign lb_in[g] = lb_out[g-1];
    end
    conv_line_buffer #(
      .PIXEL_WIDTH (PW),
      .DEPTH       (IMAGE_WIDTH),
      .AW          (CW)
    ) u_lb (
      .clock   (clock),
      .wr_en_i (in_valid),
      .addr_i  (col_cur),
      .din_i   (lb_in[g]),
      .dout_o  (lb_out[g])
    );
  end

  // New window column, top (oldest row) to bottom (current row).
  logic [K-1:0][PW-1:0] new_col;

  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign new_col[r] = lb_out[K-2-r];
  end
  assign new_col[K-1] = in_pixel;

  // ---------------------------------------------------------------------
  // Window registers. Packed [r][c][bit] places element r*K+c at bit
  // offset (r*K+c)*PW, which is exactly the multiply-adder operand layout.
  // ---------------------------------------------------------------------
  logic [K-1:0][K-1:0][PW-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = new_col[r];
      end
    end
  end

  logic out_valid_q, frame_done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      out_valid_q  <= win_done;
      frame_done_q <= frame_end;
    end
  end

  assign out_window     = win_q;
  assign out_valid      = out_valid_q;
  assign out_frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
//   Two instances: K=3, 5x5 image and K=2, 4x3 image. Pixel value is
//   base + row*W + col. Expected windows come from hand-written tables
//   keyed by the completing pixel index; they are queued with the cycle in
//   which out_valid must appear and compared by a negedge monitor.
module tb_conv_window_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        v3, s3, ov3, fd3;
  logic [7:0]  p3;
  logic [71:0] w3;
  logic        v2, s2, ov2, fd2;
  logic [7:0]  p2;
  logic [31:0] w2;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  conv_window_gen #(
    .PIXEL_WIDTH (8), .KERNEL_SIZE (3), .IMAGE_WIDTH (5), .IMAGE_HEIGHT (5)
  ) dut3 (
    .clock (clock), .reset (reset), .in_valid (v3), .in_sof (s3),
    .in_pixel (p3), .out_valid (ov3), .out_window (w3), .out_frame_done (fd3)
  );

  conv_window_gen #(
    .PIXEL_WIDTH (8), .KERNEL_SIZE (2), .IMAGE_WIDTH (4), .IMAGE_HEIGHT (3)
  ) dut2 (
    .clock (clock), .reset (reset), .in_valid (v2), .in_sof (s2),
    .in_pixel (p2), .out_valid (ov2), .out_window (w2), .out_frame_done (fd2)
  );

  typedef struct { int trig; int w[9]; bit done; } vec3_t;
  typedef struct { int trig; int w[4]; bit done; } vec2_t;
  typedef struct { logic [71:0] win; bit done; int due; } exp3_t;
  typedef struct { logic [31:0] win; bit done; int due; } exp2_t;

  vec3_t t3 [9];
  vec2_t t2 [6];
  exp3_t q3 [$];
  exp2_t q2 [$];

  int n_chk  = 0;
  int n_fail = 0;
  int r3, c3, r2, c2;

  task automatic chk(input bit ok, input string name,
                     input logic [71:0] act, input logic [71:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic mon();
    exp3_t e;
    exp2_t f;
    if (ov3) begin
      if (q3.size() == 0) chk(1'b0, "k3 unexpected window", w3, '0);
      else begin
        e = q3.pop_front();
        chk(w3 == e.win,   "k3 window",     w3,  e.win);
        chk(fd3 == e.done, "k3 frame_done", fd3, e.done);
        chk(cyc == e.due,  "k3 latency",    cyc, e.due);
      end
    end else if (q3.size() > 0 && q3[0].due <= cyc) begin
      e = q3.pop_front();
      chk(1'b0, "k3 missing window", '0, e.win);
    end
    if (fd3 && !ov3) chk(1'b0, "k3 stray frame_done", fd3, '0);

    if (ov2) begin
      if (q2.size() == 0) chk(1'b0, "k2 unexpected window", w2, '0);
      else begin
        f = q2.pop_front();
        chk(w2 == f.win,   "k2 window",     w2,  f.win);
        chk(fd2 == f.done, "k2 frame_done", fd2, f.done);
        chk(cyc == f.due,  "k2 latency",    cyc, f.due);
      end
    end else if (q2.size() > 0 && q2[0].due <= cyc) begin
      f = q2.pop_front();
      chk(1'b0, "k2 missing window", '0, f.win);
    end
    if (fd2 && !ov2) chk(1'b0, "k2 stray frame_done", fd2, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send3(input bit sof, input int base);
    exp3_t e;
    int    idx;
    if (sof) begin r3 = 0; c3 = 0; end
    idx = r3 * 5 + c3;
    if (r3 >= 2 && c3 >= 2) begin
      e.win  = '0;
      e.done = 1'b0;
      for (int k = 0; k < 9; k++) if (t3[k].trig == idx) begin
        for (int i = 0; i < 9; i++) e.win[8*i +: 8] = 8'(base + t3[k].w[i]);
        e.done = t3[k].done;
      end
      e.due = cyc + 1;
      q3.push_back(e);
    end
    v3 = 1'b1; s3 = sof; p3 = 8'(base + idx);
    @(posedge clock); #1;
    v3 = 1'b0; s3 = 1'b0;
    if (c3 == 4) begin c3 = 0; r3 = (r3 == 4) ? 0 : r3 + 1; end
    else c3++;
  endtask

  task automatic send2(input bit sof, input int base);
    exp2_t f;
    int    idx;
    if (sof) begin r2 = 0; c2 = 0; end
    idx = r2 * 4 + c2;
    if (r2 >= 1 && c2 >= 1) begin
      f.win  = '0;
      f.done = 1'b0;
      for (int k = 0; k < 6; k++) if (t2[k].trig == idx) begin
        for (int i = 0; i < 4; i++) f.win[8*i +: 8] = 8'(base + t2[k].w[i]);
        f.done = t2[k].done;
      end
      f.due = cyc + 1;
      q2.push_back(f);
    end
    v2 = 1'b1; s2 = sof; p2 = 8'(base + idx);
    @(posedge clock); #1;
    v2 = 1'b0; s2 = 1'b0;
    if (c2 == 3) begin c2 = 0; r2 = (r2 == 2) ? 0 : r2 + 1; end
    else c2++;
  endtask

  task automatic frame3(input bit sof, input int base, input int maxgap);
    for (int i = 0; i < 25; i++) begin
      send3(sof && i == 0, base);
      if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (q3.size() > 0 || q2.size() > 0); i++) idle(1);
    chk(q3.size() == 0 && q2.size() == 0, "scoreboard drained",
        72'(q3.size() + q2.size()), '0);
  endtask

  initial begin
    t3[0] = '{12, '{ 0, 1, 2,  5, 6, 7, 10,11,12}, 1'b0};
    t3[1] = '{13, '{ 1, 2, 3,  6, 7, 8, 11,12,13}, 1'b0};
    t3[2] = '{14, '{ 2, 3, 4,  7, 8, 9, 12,13,14}, 1'b0};
    t3[3] = '{17, '{ 5, 6, 7, 10,11,12, 15,16,17}, 1'b0};
    t3[4] = '{18, '{ 6, 7, 8, 11,12,13, 16,17,18}, 1'b0};
    t3[5] = '{19, '{ 7, 8, 9, 12,13,14, 17,18,19}, 1'b0};
    t3[6] = '{22, '{10,11,12, 15,16,17, 20,21,22}, 1'b0};
    t3[7] = '{23, '{11,12,13, 16,17,18, 21,22,23}, 1'b0};
    t3[8] = '{24, '{12,13,14, 17,18,19, 22,23,24}, 1'b1};
    t2[0] = '{ 5, '{0,1, 4, 5}, 1'b0};
    t2[1] = '{ 6, '{1,2, 5, 6}, 1'b0};
    t2[2] = '{ 7, '{2,3, 6, 7}, 1'b0};
    t2[3] = '{ 9, '{4,5, 8, 9}, 1'b0};
    t2[4] = '{10, '{5,6, 9,10}, 1'b0};
    t2[5] = '{11, '{6,7,10,11}, 1'b1};

    reset = 1'b0;
    v3 = 1'b0; s3 = 1'b0; p3 = '0;
    v2 = 1'b0; s2 = 1'b0; p2 = '0;
    r3 = 0; c3 = 0; r2 = 0; c2 = 0;

    fork
      forever begin @(negedge clock); mon(); end
    join_none

    #2;
    chk(ov3 == 1'b0, "reset k3 out_valid",      ov3, '0);
    chk(w3  == '0,   "reset k3 out_window",     w3,  '0);
    chk(fd3 == 1'b0, "reset k3 out_frame_done", fd3, '0);
    chk(ov2 == 1'b0, "reset k2 out_valid",      ov2, '0);
    chk(w2  == '0,   "reset k2 out_window",     w2,  '0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // Single frame, continuous.
    frame3(1'b1, 0, 0);
    drain();

    // Same frame with random 0..3 cycle gaps.
    frame3(1'b1, 0, 3);
    drain();

    // Two back-to-back frames, sof only on the first; frame 2 offset by 100
    // so any frame-1 pixel leaking into a frame-2 window shows up.
    frame3(1'b1, 0, 0);
    frame3(1'b0, 100, 0);
    drain();

    // Resync: in_sof at (3,1) aborts the partial frame.
    for (int i = 0; i < 16; i++) send3(i == 0, 0);
    frame3(1'b1, 0, 0);
    drain();

    // Reset after pixel 13, then a full frame without sof.
    for (int i = 0; i < 14; i++) send3(i == 0, 0);
    idle(1);
    reset = 1'b0;
    #1;
    chk(ov3 == 1'b0, "midreset k3 out_valid",      ov3, '0);
    chk(w3  == '0,   "midreset k3 out_window",     w3,  '0);
    chk(fd3 == 1'b0, "midreset k3 out_frame_done", fd3, '0);
    idle(2);
    reset = 1'b1;
    r3 = 0; c3 = 0; r2 = 0; c2 = 0;
    idle(1);
    frame3(1'b0, 0, 0);
    drain();

    // K=2, 4x3: one frame with sof, then a second auto-wrapped frame.
    for (int i = 0; i < 12; i++) send2(i == 0, 0);
    for (int i = 0; i < 12; i++) send2(1'b0, 40);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
